// File: rtl/ann_weight_port_if.sv
// ann_weight_port_if: host weight-transfer bus plus engine read/write port of the ANN weight bank.
interface ann_weight_port_if #(
  parameter int WIDTH = 156,
  parameter int AW = 6
);
  logic [WIDTH-1:0] Weight_in;
  logic Weight_Save_enable;
  logic Weight_Load_enable;
  logic [WIDTH-1:0] New_weight_out;
  logic Bank_valid;
  logic Busy;
  logic Err;
  logic [AW-1:0] eng_rd_addr;
  logic [WIDTH-1:0] eng_rd_data;
  logic eng_wr_en;
  logic [AW-1:0] eng_wr_addr;
  logic [WIDTH-1:0] eng_wr_data;
  logic [15:0] Save_sum;
  logic [15:0] Load_sum;
  modport master (
    output Weight_in, Weight_Save_enable, Weight_Load_enable,
    output eng_rd_addr, eng_wr_en, eng_wr_addr, eng_wr_data,
    input New_weight_out, Bank_valid, Busy, Err, eng_rd_data, Save_sum, Load_sum
  );
  modport slave (
    input Weight_in, Weight_Save_enable, Weight_Load_enable,
    input eng_rd_addr, eng_wr_en, eng_wr_addr, eng_wr_data,
    output New_weight_out, Bank_valid, Busy, Err, eng_rd_data, Save_sum, Load_sum
  );
endinterface

// File: rtl/ann_weight_port.sv
// ann_weight_port: ANN-side responder storing/streaming a weight bank for the host, with an engine port.
// Define ANN_WEIGHT_CHECKSUM_EN to generate the Save_sum/Load_sum 16-bit checksums.
module ann_weight_port #(
  parameter int WIDTH = 156,
  parameter int WEIGHT_NUM = 40,
  parameter int AW = 6
) (
  input logic Clk,
  input logic Reset_l,
  ann_weight_port_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SAVE, LOAD} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] bank [WEIGHT_NUM];
  logic [AW-1:0] wr_ptr, rd_ptr, load_idx, bank_wa;
  logic [WIDTH-1:0] new_out, bank_wd;
  logic bank_valid, err, busy;
  logic save, load, idle, in_save, in_load, full;
  logic save_start, load_start, save_fire, load_fire, eng_ok, bank_we, err_set;
  assign save = bus.Weight_Save_enable;
  assign load = bus.Weight_Load_enable;
  always_ff @(posedge Clk or negedge Reset_l) begin
    if (!Reset_l) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = (save && !load) ? SAVE : (load && !save) ? LOAD : IDLE;
      SAVE: state_nx = save ? SAVE : IDLE;
      LOAD: state_nx = load ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = (state == SAVE) || (state == LOAD);
  end
  // The IDLE entry edge already moves word 0, so the burst pointers behave as if starting at index 0.
  always_comb begin
    idle = state == IDLE;
    in_save = state == SAVE;
    in_load = state == LOAD;
    full = wr_ptr == AW'(WEIGHT_NUM);
    save_start = idle && save && !load;
    load_start = idle && load && !save;
    save_fire = save_start || (in_save && save && !full);
    load_fire = load_start || (in_load && load);
    load_idx = idle ? '0 : rd_ptr;
    eng_ok = bus.eng_wr_en && idle && !save_start && (bus.eng_wr_addr < AW'(WEIGHT_NUM));
    bank_we = save_fire || eng_ok;
    bank_wa = save_fire ? wr_ptr : bus.eng_wr_addr;
    bank_wd = save_fire ? bus.Weight_in : bus.eng_wr_data;
    err_set = (idle && save && load) || (in_save && (load || (save && full))) ||
              (in_load && save) || (bus.eng_wr_en && !eng_ok);
  end
  always_ff @(posedge Clk) begin
    if (bank_we) bank[bank_wa] <= bank_wd;
  end
  always_ff @(posedge Clk or negedge Reset_l) begin
    if (!Reset_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      new_out <= '0;
      bank_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      if (err_set) err <= 1'b1;
      if (save_fire) wr_ptr <= wr_ptr + AW'(1);
      if (save_start) bank_valid <= 1'b0;
      if (in_save && !save) begin
        wr_ptr <= '0;
        bank_valid <= full;
      end
      if (load_fire) begin
        new_out <= bank[load_idx];
        rd_ptr <= (load_idx == AW'(WEIGHT_NUM - 1)) ? '0 : load_idx + AW'(1);
      end
      if (in_load && !load) rd_ptr <= '0;
    end
  end
`ifdef ANN_WEIGHT_CHECKSUM_EN
  logic [15:0] save_sum, load_sum;
  always_ff @(posedge Clk or negedge Reset_l) begin
    if (!Reset_l) begin
      save_sum <= '0;
      load_sum <= '0;
    end else begin
      if (save_fire) save_sum <= (save_start ? 16'd0 : save_sum) + bus.Weight_in[15:0];
      if (load_fire) load_sum <= (load_start ? 16'd0 : load_sum) + bank[load_idx][15:0];
    end
  end
  assign bus.Save_sum = save_sum;
  assign bus.Load_sum = load_sum;
`else
  assign bus.Save_sum = '0;
  assign bus.Load_sum = '0;
`endif
  assign bus.New_weight_out = new_out;
  assign bus.Bank_valid = bank_valid;
  assign bus.Busy = busy;
  assign bus.Err = err;
  assign bus.eng_rd_data = (bus.eng_rd_addr < AW'(WEIGHT_NUM)) ? bank[bus.eng_rd_addr] : '0;
endmodule

// File: tb/tb_ann_weight_port.sv
// tb_ann_weight_port: scoreboard bench for save/load bursts, protocol errors and the engine port.
module tb_ann_weight_port;
  localparam int WIDTH = 156;
  localparam int WN = 40;
  localparam int AW = 6;
  logic Clk = 1'b0;
  logic Reset_l = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] model [WN];
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] exp_w;
  ann_weight_port_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
  ann_weight_port #(.WIDTH(WIDTH), .WEIGHT_NUM(WN), .AW(AW)) dut (.Clk(Clk), .Reset_l(Reset_l), .bus(bus));
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Weight_in = '0;
    bus.Weight_Save_enable = 1'b0;
    bus.Weight_Load_enable = 1'b0;
    bus.eng_rd_addr = '0;
    bus.eng_wr_en = 1'b0;
    bus.eng_wr_addr = '0;
    bus.eng_wr_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset_l = 1'b0;
    tick();
    Reset_l = 1'b1;
    tick();
  endtask

  task automatic save_burst(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      bus.Weight_in = WIDTH'(base + i);
      bus.Weight_Save_enable = 1'b1;
      if (i < WN) model[i] = WIDTH'(base + i);
      tick();
    end
    bus.Weight_Save_enable = 1'b0;
    tick();
  endtask

  task automatic read_bank(input int a, output logic [WIDTH-1:0] d);
    bus.eng_rd_addr = AW'(a);
    #1;
    d = bus.eng_rd_data;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 Reset_l = 1'b0;
    #1;
    vectors += 5;
    if (bus.New_weight_out !== '0) begin miscompares++; $display("FAIL reset_out got=%0h exp=0", bus.New_weight_out); end
    if (bus.Bank_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", bus.Bank_valid); end
    if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
    if (bus.Err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", bus.Err); end
    if (bus.Save_sum !== 16'd0 || bus.Load_sum !== 16'd0) begin miscompares++; $display("FAIL reset_sums got=%0h/%0h exp=0/0", bus.Save_sum, bus.Load_sum); end
    tick();
    Reset_l = 1'b1;
    tick();
  endtask

  task automatic test_save_load();
    logic [WIDTH-1:0] d;
    save_burst(WN, 1);
    read_bank(39, d);
    vectors += 5;
    if (bus.Bank_valid !== 1'b1) begin miscompares++; $display("FAIL save_valid got=%b exp=1", bus.Bank_valid); end
    if (bus.Err !== 1'b0) begin miscompares++; $display("FAIL save_err got=%b exp=0", bus.Err); end
    if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL save_busy got=%b exp=0", bus.Busy); end
    if (d !== WIDTH'(40)) begin miscompares++; $display("FAIL save_bank39 got=%0h exp=28", d); end
`ifdef ANN_WEIGHT_CHECKSUM_EN
    if (bus.Save_sum !== 16'h0334) begin miscompares++; $display("FAIL save_sum got=%0h exp=334", bus.Save_sum); end
`else
    if (bus.Save_sum !== 16'h0000) begin miscompares++; $display("FAIL save_sum got=%0h exp=0", bus.Save_sum); end
`endif
    bus.Weight_Load_enable = 1'b1;
    for (int i = 0; i <= WN; i++) begin
      exp_q.push_back(model[i % WN]);
      tick();
      exp_w = exp_q.pop_front();
      vectors += 2;
      if (bus.New_weight_out !== exp_w) begin miscompares++; $display("FAIL load_word%0d got=%0h exp=%0h", i, bus.New_weight_out, exp_w); end
      if (bus.Busy !== 1'b1) begin miscompares++; $display("FAIL load_busy%0d got=%b exp=1", i, bus.Busy); end
      if (i == WN - 1) begin
        vectors++;
`ifdef ANN_WEIGHT_CHECKSUM_EN
        if (bus.Load_sum !== 16'h0334) begin miscompares++; $display("FAIL load_sum got=%0h exp=334", bus.Load_sum); end
`else
        if (bus.Load_sum !== 16'h0000) begin miscompares++; $display("FAIL load_sum got=%0h exp=0", bus.Load_sum); end
`endif
      end
    end
    bus.Weight_Load_enable = 1'b0;
    tick();
    vectors += 3;
    if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL load_exit_busy got=%b exp=0", bus.Busy); end
    if (bus.New_weight_out !== WIDTH'(1)) begin miscompares++; $display("FAIL load_hold got=%0h exp=1", bus.New_weight_out); end
    if (bus.Err !== 1'b0) begin miscompares++; $display("FAIL load_err got=%b exp=0", bus.Err); end
  endtask

  task automatic test_short_and_overflow();
    logic [WIDTH-1:0] d;
    save_burst(25, 1000);
    read_bank(25, d);
    vectors += 3;
    if (bus.Bank_valid !== 1'b0) begin miscompares++; $display("FAIL short_valid got=%b exp=0", bus.Bank_valid); end
    if (bus.Err !== 1'b0) begin miscompares++; $display("FAIL short_err got=%b exp=0", bus.Err); end
    if (d !== model[25]) begin miscompares++; $display("FAIL short_bank25 got=%0h exp=%0h", d, model[25]); end
    save_burst(42, 2000);
    vectors += 4;
    if (bus.Err !== 1'b1) begin miscompares++; $display("FAIL ovf_err got=%b exp=1", bus.Err); end
    if (bus.Bank_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid got=%b exp=1", bus.Bank_valid); end
    read_bank(39, d);
    if (d !== WIDTH'(2039)) begin miscompares++; $display("FAIL ovf_bank39 got=%0h exp=%0h", d, WIDTH'(2039)); end
    read_bank(0, d);
    if (d !== WIDTH'(2000)) begin miscompares++; $display("FAIL ovf_bank0 got=%0h exp=%0h", d, WIDTH'(2000)); end
  endtask

  task automatic test_both_strobes();
    logic [WIDTH-1:0] d;
    do_reset();
    bus.Weight_in = WIDTH'(77);
    bus.Weight_Save_enable = 1'b1;
    bus.Weight_Load_enable = 1'b1;
    tick();
    vectors += 3;
    if (bus.Err !== 1'b1) begin miscompares++; $display("FAIL both_err got=%b exp=1", bus.Err); end
    if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL both_busy got=%b exp=0", bus.Busy); end
    idle_inputs();
    tick();
    read_bank(0, d);
    if (d !== model[0]) begin miscompares++; $display("FAIL both_bank0 got=%0h exp=%0h", d, model[0]); end
  endtask

  task automatic test_engine();
    logic [WIDTH-1:0] d;
    do_reset();
    bus.eng_wr_en = 1'b1;
    bus.eng_wr_addr = AW'(5);
    bus.eng_wr_data = WIDTH'('hABC);
    tick();
    model[5] = WIDTH'('hABC);
    bus.eng_wr_en = 1'b0;
    read_bank(5, d);
    vectors += 3;
    if (d !== WIDTH'('hABC)) begin miscompares++; $display("FAIL eng_wr5 got=%0h exp=abc", d); end
    if (bus.Err !== 1'b0) begin miscompares++; $display("FAIL eng_ok_err got=%b exp=0", bus.Err); end
    if (bus.Bank_valid !== 1'b0) begin miscompares++; $display("FAIL eng_valid got=%b exp=0", bus.Bank_valid); end
    bus.eng_wr_en = 1'b1;
    bus.eng_wr_addr = AW'(45);
    tick();
    bus.eng_wr_en = 1'b0;
    read_bank(45, d);
    vectors += 2;
    if (bus.Err !== 1'b1) begin miscompares++; $display("FAIL eng_oor_err got=%b exp=1", bus.Err); end
    if (d !== '0) begin miscompares++; $display("FAIL eng_rd45 got=%0h exp=0", d); end
    do_reset();
    bus.Weight_Load_enable = 1'b1;
    tick();
    bus.eng_wr_en = 1'b1;
    bus.eng_wr_addr = AW'(6);
    bus.eng_wr_data = WIDTH'('h555);
    tick();
    idle_inputs();
    tick();
    read_bank(6, d);
    vectors += 2;
    if (d !== model[6]) begin miscompares++; $display("FAIL eng_load_drop got=%0h exp=%0h", d, model[6]); end
    if (bus.Err !== 1'b1) begin miscompares++; $display("FAIL eng_load_err got=%b exp=1", bus.Err); end
  endtask

  task automatic test_reset_mid_burst();
    logic [WIDTH-1:0] d;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bus.Weight_in = WIDTH'(3000 + i);
      bus.Weight_Save_enable = 1'b1;
      model[i] = WIDTH'(3000 + i);
      tick();
    end
    #2 Reset_l = 1'b0;
    #1;
    vectors++;
    if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got=%b exp=0", bus.Busy); end
    bus.Weight_Save_enable = 1'b0;
    tick();
    Reset_l = 1'b1;
    tick();
    save_burst(WN, 4000);
    read_bank(0, d);
    vectors += 4;
    if (bus.Bank_valid !== 1'b1) begin miscompares++; $display("FAIL mid_valid got=%b exp=1", bus.Bank_valid); end
    if (bus.Err !== 1'b0) begin miscompares++; $display("FAIL mid_err got=%b exp=0", bus.Err); end
    if (d !== WIDTH'(4000)) begin miscompares++; $display("FAIL mid_bank0 got=%0h exp=%0h", d, WIDTH'(4000)); end
    read_bank(39, d);
    if (d !== model[39]) begin miscompares++; $display("FAIL mid_bank39 got=%0h exp=%0h", d, model[39]); end
  endtask

  initial begin
    for (int i = 0; i < WN; i++) model[i] = 'x;
    test_reset();
    test_save_load();
    test_short_and_overflow();
    test_both_strobes();
    test_engine();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
